// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: controller state, forwarding selects and the
// load-use hazard predicate used by the hazard unit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    START  = 2'd0,
    RUN    = 2'd1,
    FREEZE = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  // A load in EX feeding a register actually read in ID; x0 never creates a hazard.
  function automatic logic load_use_hazard(
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic [4:0] id_rs2,
    input logic       use_rs1,
    input logic       use_rs2
  );
    return ex_mem_read && (ex_rd != 5'd0) &&
           ((use_rs1 && (ex_rd == id_rs1)) || (use_rs2 && (ex_rd == id_rs2)));
  endfunction

endpackage

// File: rtl/pipe_ctrl_fwd_sel.sv
// Forwarding select for one EX operand; the youngest producer (EX/MEM) wins
// over MEM/WB, and loads in EX/MEM cannot forward because their data is not ready.
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_RegWrite,
  input  logic       mem_Mem2Reg,
  input  logic [4:0] wb_rd,
  input  logic       wb_RegWrite,
  output fwd_sel_t   sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_RegWrite && !mem_Mem2Reg && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
      sel = FWD_MEM;
    end else if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: register enables,
// flushes, PC select, EX forwarding and stall/squash performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRead,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_RegWrite,
  input  logic             mem_Mem2Reg,
  input  logic             wb_RegWrite,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             pc_sel,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  ctrl_state_t state, state_next;

  logic     freeze_now;
  logic     frozen;
  logic     active;
  logic     branch;
  logic     load_use;
  fwd_sel_t fwd_a_raw, fwd_b_raw;

  assign freeze_now = mem_req & ~dmem_ready;

  // The FREEZE cycle that sees dmem_ready already behaves as RUN, so the
  // pipeline advances on the completing cycle and a held branch fires there.
  assign frozen   = ((state == RUN) & freeze_now) | ((state == FREEZE) & ~dmem_ready);
  assign active   = ((state == RUN) | (state == FREEZE)) & ~frozen;
  assign branch   = active & ex_branch_taken;
  assign load_use = active & ~ex_branch_taken &
                    load_use_hazard(ex_MemRead, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= START;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      START:   state_next = RUN;
      RUN:     if (freeze_now) state_next = FREEZE;
      FREEZE:  if (dmem_ready) state_next = RUN;
      default: state_next = START;
    endcase
  end

  always_comb begin
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    id_ex_we    = 1'b0;
    ex_mem_we   = 1'b0;
    mem_wb_we   = 1'b0;
    pc_sel      = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state == START) begin
      {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = '1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (active) begin
      {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = '1;
      if (branch) begin
        pc_sel      = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  fwd_sel u_fwd_a (
    .ex_rs        (ex_rs1),
    .mem_rd       (mem_rd),
    .mem_RegWrite (mem_RegWrite),
    .mem_Mem2Reg  (mem_Mem2Reg),
    .wb_rd        (wb_rd),
    .wb_RegWrite  (wb_RegWrite),
    .sel          (fwd_a_raw)
  );

  fwd_sel u_fwd_b (
    .ex_rs        (ex_rs2),
    .mem_rd       (mem_rd),
    .mem_RegWrite (mem_RegWrite),
    .mem_Mem2Reg  (mem_Mem2Reg),
    .wb_rd        (wb_rd),
    .wb_RegWrite  (wb_RegWrite),
    .sel          (fwd_b_raw)
  );

  assign fwd_a = rst ? FWD_RF : fwd_a_raw;
  assign fwd_b = rst ? FWD_RF : fwd_b_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if ((state != START) && !pc_we) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (branch) begin
        flush_count <= flush_count + CNT_W'(2);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: reset, load-use, branch, freeze,
// forwarding and reset during a memory wait.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, ex_MemRead, ex_branch_taken;
  logic        mem_RegWrite, mem_Mem2Reg, wb_RegWrite, mem_req, dmem_ready;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        pc_sel, if_id_flush, id_ex_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cycles, flush_count;
  logic [7:0]  ctl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, pc_sel, if_id_flush, id_ex_flush}
  assign ctl = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, pc_sel, if_id_flush, id_ex_flush};

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rs1          (ex_rs1),
    .ex_rs2          (ex_rs2),
    .ex_rd           (ex_rd),
    .ex_MemRead      (ex_MemRead),
    .ex_branch_taken (ex_branch_taken),
    .mem_rd          (mem_rd),
    .wb_rd           (wb_rd),
    .mem_RegWrite    (mem_RegWrite),
    .mem_Mem2Reg     (mem_Mem2Reg),
    .wb_RegWrite     (wb_RegWrite),
    .mem_req         (mem_req),
    .dmem_ready      (dmem_ready),
    .pc_we           (pc_we),
    .if_id_we        (if_id_we),
    .id_ex_we        (id_ex_we),
    .ex_mem_we       (ex_mem_we),
    .mem_wb_we       (mem_wb_we),
    .pc_sel          (pc_sel),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    mem_rd = '0; wb_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_MemRead = 1'b0; ex_branch_taken = 1'b0;
    mem_RegWrite = 1'b0; mem_Mem2Reg = 1'b0; wb_RegWrite = 1'b0;
    mem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    ex_rs1 = 5'd7; mem_rd = 5'd7; mem_RegWrite = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ctl !== 8'b0000_0011) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 8'b0000_0011); end
    checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a got %b exp 00", fwd_a); end
    checks++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cycles, flush_count); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ctl !== 8'b1111_1011) begin errors++; $display("FAIL start_ctl got %b exp %b", ctl, 8'b1111_1011); end
    step();
    #1;
    checks++; if (ctl !== 8'b1111_1000) begin errors++; $display("FAIL run_ctl got %b exp %b", ctl, 8'b1111_1000); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL run_stall got %0d exp 0", stall_cycles); end
  endtask

  task automatic test_load_use();
    ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    #1;
    checks++; if (ctl !== 8'b0011_1001) begin errors++; $display("FAIL lu_ctl got %b exp %b", ctl, 8'b0011_1001); end
    step();
    clear_inputs();
    #1;
    checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL lu_stall got %0d exp 1", stall_cycles); end
    checks++; if (ctl !== 8'b1111_1000) begin errors++; $display("FAIL lu_release got %b exp %b", ctl, 8'b1111_1000); end
    ex_MemRead = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
    #1;
    checks++; if (ctl !== 8'b1111_1000) begin errors++; $display("FAIL lu_x0 got %b exp %b", ctl, 8'b1111_1000); end
    ex_rd = 5'd6; id_rs1 = 5'd6; id_use_rs1 = 1'b0; id_rs2 = 5'd1;
    #1;
    checks++; if (ctl !== 8'b1111_1000) begin errors++; $display("FAIL lu_unused got %b exp %b", ctl, 8'b1111_1000); end
    step();
    clear_inputs();
    #1;
    checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL lu_nostall got %0d exp 1", stall_cycles); end
  endtask

  task automatic test_branch();
    ex_branch_taken = 1'b1;
    ex_MemRead = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1'b1;
    #1;
    checks++; if (ctl !== 8'b1111_1111) begin errors++; $display("FAIL br_ctl got %b exp %b", ctl, 8'b1111_1111); end
    step();
    clear_inputs();
    #1;
    checks++; if (flush_count !== 32'd2) begin errors++; $display("FAIL br_flush got %0d exp 2", flush_count); end
    checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL br_stall got %0d exp 1", stall_cycles); end
  endtask

  task automatic test_freeze();
    mem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== 8'b0000_0000) begin errors++; $display("FAIL frz_ctl%0d got %b exp %b", i, ctl, 8'b0000_0000); end
      step();
    end
    dmem_ready = 1'b1;
    #1;
    checks++; if (stall_cycles !== 32'd4) begin errors++; $display("FAIL frz_stall got %0d exp 4", stall_cycles); end
    checks++; if (ctl !== 8'b1111_1111) begin errors++; $display("FAIL frz_exit_branch got %b exp %b", ctl, 8'b1111_1111); end
    step();
    clear_inputs();
    #1;
    checks++; if (flush_count !== 32'd4) begin errors++; $display("FAIL frz_flush got %0d exp 4", flush_count); end
    checks++; if (ctl !== 8'b1111_1000) begin errors++; $display("FAIL frz_run got %b exp %b", ctl, 8'b1111_1000); end
    mem_req = 1'b1; dmem_ready = 1'b1;
    #1;
    checks++; if (ctl !== 8'b1111_1000) begin errors++; $display("FAIL same_cycle_ready got %b exp %b", ctl, 8'b1111_1000); end
    step();
    mem_req = 1'b0; dmem_ready = 1'b0;
    #1;
    checks++; if (stall_cycles !== 32'd4 || ctl !== 8'b1111_1000) begin errors++; $display("FAIL same_cycle_state got %0d/%b exp 4/%b", stall_cycles, ctl, 8'b1111_1000); end
  endtask

  task automatic test_forwarding();
    ex_rs1 = 5'd7; mem_rd = 5'd7; mem_RegWrite = 1'b1; wb_rd = 5'd7; wb_RegWrite = 1'b1;
    #1;
    checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_mem got %b exp 01", fwd_a); end
    mem_Mem2Reg = 1'b1;
    #1;
    checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL fwd_load_wb got %b exp 10", fwd_a); end
    mem_Mem2Reg = 1'b0; ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    #1;
    checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_x0 got %b exp 00", fwd_a); end
    ex_rs1 = 5'd2; ex_rs2 = 5'd3; mem_rd = 5'd3; mem_RegWrite = 1'b0; wb_rd = 5'd3;
    #1;
    checks++; if (fwd_b !== 2'b10 || fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_b_wb got %b/%b exp 10/00", fwd_b, fwd_a); end
    mem_RegWrite = 1'b1; mem_rd = 5'd2;
    #1;
    checks++; if (fwd_a !== 2'b01 || fwd_b !== 2'b10) begin errors++; $display("FAIL fwd_split got %b/%b exp 01/10", fwd_a, fwd_b); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_freeze();
    mem_req = 1'b1; dmem_ready = 1'b0;
    step();
    #1;
    checks++; if (ctl !== 8'b0000_0000 || stall_cycles !== 32'd5) begin errors++; $display("FAIL mid_frz_pre got %b/%0d exp 00000000/5", ctl, stall_cycles); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (ctl !== 8'b0000_0011) begin errors++; $display("FAIL mid_frz_rst_ctl got %b exp %b", ctl, 8'b0000_0011); end
    checks++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin errors++; $display("FAIL mid_frz_rst_cnt got %0d/%0d exp 0/0", stall_cycles, flush_count); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ctl !== 8'b1111_1011) begin errors++; $display("FAIL mid_frz_start got %b exp %b", ctl, 8'b1111_1011); end
    step();
    #1;
    checks++; if (ctl !== 8'b1111_1000 || stall_cycles !== 32'd0) begin errors++; $display("FAIL mid_frz_run got %b/%0d exp %b/0", ctl, stall_cycles, 8'b1111_1000); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_freeze();
    test_forwarding();
    test_reset_mid_freeze();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central hazard and sequencing controller for the 5-stage RV32I pipeline. It drives the write-enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and produces the EX-stage operand forwarding selects. It freezes the whole pipeline while a data-memory access is outstanding. It also keeps two performance counters for stall cycles and squashed instructions.

## Interface
- CNT_W, 32, width of the performance counters
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rs1, ex_rs2, ex_rd  in  5  from ID/EX (EX_STATE rs1/rs2/rd)
- ex_MemRead  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- mem_rd, wb_rd  in  5  destinations in EX/MEM and MEM/WB
- mem_RegWrite, mem_Mem2Reg, wb_RegWrite  in  1  writeback flags of MEM/WB stages
- mem_req  in  1  MEM stage is issuing a data access
- dmem_ready  in  1  data memory completes access this cycle
- pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1  register enables
- pc_sel  out  1  1 = load PC from branch target
- if_id_flush, id_ex_flush  out  1  load bubble (all-zero control) into register
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- stall_cycles, flush_count  out  CNT_W  performance counters

## Operation
- States: START, RUN, FREEZE. Reset forces START.
- START lasts one cycle: pc_we=1, if_id_flush=1, id_ex_flush=1, other enables 1. Then the block goes to RUN.
- freeze_now = mem_req & ~dmem_ready.
  - RUN→FREEZE when freeze_now.
  - FREEZE→RUN on dmem_ready.
  - In FREEZE, and in the RUN cycle where freeze_now holds, all five enables are 0 and there are no flushes. pc_sel=0 and the branch is held for later.
- Branch (RUN, not freezing, ex_branch_taken): pc_sel=1, if_id_flush=1, id_ex_flush=1, all enables 1.
- Load-use (RUN, not freezing, no branch):
  - Condition: ex_MemRead & ex_rd≠0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
  - Response: pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=mem_wb_we=1.
- Priority: freeze > branch > load-use. A load-use hazard coinciding with a branch is ignored because ID is squashed.
- Forwarding is computed per operand, independent of state.
  - 01 if mem_RegWrite & ~mem_Mem2Reg & mem_rd≠0 & mem_rd==ex_rsN.
  - Otherwise 10 if wb_RegWrite & wb_rd≠0 & wb_rd==ex_rsN.
  - Otherwise 00. MEM has priority over WB.
- Counters (wrap modulo 2^CNT_W, cleared only by reset):
  - stall_cycles +1 on every RUN/FREEZE cycle with pc_we=0.
  - flush_count +2 on every branch flush.

## Timing
- All control outputs are combinational from state and inputs and act in the same cycle.
- State and counters update on the rising clk edge.
- While rst=1: pc_we=if_id_we=id_ex_we=ex_mem_we=mem_wb_we=0, if_id_flush=id_ex_flush=1, pc_sel=0, fwd_a=fwd_b=00, counters 0, state START.
- Reset asserted mid-FREEZE aborts the wait immediately; the first cycle after release is START.
- dmem_ready in the same cycle as mem_req means no freeze and no state change.
- A branch held during FREEZE takes effect in the first RUN cycle after exit.

## Structure
- Add to the shared PipelineReg package:
  - ctrl_state_t enum {START, RUN, FREEZE}
  - fwd_sel_t constants FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
- One sub-module, fwd_sel: combinational comparator for one operand, instantiated twice (rs1, rs2).

## Test plan
- Reset release: cycle 0 shows pc_we=1, if_id_flush=1, id_ex_flush=1; cycle 1 is RUN with all enables 1 and stall_cycles=0.
- lw x5 in EX, ID reads x5 via rs2 → one cycle of pc_we=0, if_id_we=0, id_ex_flush=1; stall_cycles=1. Same case with ex_rd=0 → no stall.
- ex_branch_taken together with a load-use hazard → pc_sel=1, both flushes=1, no stall, flush_count=2.
- mem_req=1 with dmem_ready low for 3 cycles → FREEZE, all enables 0 for 3 cycles, stall_cycles+=3; RUN resumes on the dmem_ready cycle.
- ex_rs1=7, mem_rd=7 (ALU op), wb_rd=7 → fwd_a=01. Same with mem_Mem2Reg=1 → fwd_a=10. mem_rd=wb_rd=0 → fwd_a=00.
- rst pulsed mid-FREEZE → outputs go to reset values immediately and counters read 0.
